// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-client RAM port arbiter.
package ram_arb_pkg;

   localparam int ARB_ADDR_W = 10;
   localparam int ARB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   // Command fields are sized by the package defaults; the top must be built with matching widths.
   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic                  owner;
   } cmd_t;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the client not granted last.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) begin
         o_gnt = onehot2(~i_last_gnt);
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two valid/ready clients onto a single-port registered-read RAM,
// one access at a time, returning read data with a per-client strobe.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_we,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        req_ready,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t     r_state;
   state_t     w_state_nxt;
   cmd_t       r_cmd;
   cmd_t       w_cmd_nxt;
   logic       r_last_gnt;
   logic [1:0] w_gnt;
   logic       w_owner;
   logic       w_accept;

   rr_arb2 u_rr_arb2 (
      .i_req      (req_valid),
      .i_last_gnt (r_last_gnt),
      .o_gnt      (w_gnt)
   );

   assign w_owner  = w_gnt[1];
   // Handshakes are suppressed while reset is sampled so nothing is accepted and then dropped.
   assign w_accept = (r_state == IDLE) && (w_gnt != 2'b00) && !rst;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (req_valid != 2'b00) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = r_cmd.we ? IDLE : RDWAIT;
         RDWAIT:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_cmd_nxt = r_cmd;
      if (w_accept) begin
         w_cmd_nxt.we    = req_we[w_owner];
         w_cmd_nxt.addr  = w_owner ? req_addr1 : req_addr0;
         w_cmd_nxt.wdata = w_owner ? req_wdata1 : req_wdata0;
         w_cmd_nxt.owner = w_owner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_last_gnt <= 1'b1;
         r_cmd      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cmd   <= w_cmd_nxt;
         if (w_accept) begin
            r_last_gnt <= w_owner;
         end
      end
   end

   // The command register doubles as the RAM address/data hold between accesses.
   always_comb begin
      req_ready = w_accept ? w_gnt : 2'b00;
      busy      = (r_state != IDLE);
      ram_we    = (r_state == ISSUE) && r_cmd.we && !rst;
      ram_addr  = r_cmd.addr;
      ram_wdata = r_cmd.wdata;
      rsp_valid = 2'b00;
      rsp_rdata = '0;
      if ((r_state == RDWAIT) && !rst) begin
         rsp_valid = onehot2(r_cmd.owner);
         rsp_rdata = ram_rdata;
      end
   end

endmodule
